// File: rtl/pc_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : pc_sequencer
//  Description : Fetch-stage next-PC generator. Chooses between sequential
//                fetch, taken branch and load-use stall, and runs the
//                interrupt-entry (push PC hi/lo, jump to vector) and
//                return (pop PC lo/hi, reload) sequences over a 16-bit
//                stack port.
//  Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
//  Ports
//    clk            in   1   clock, state updates on posedge
//    rst            in   1   asynchronous reset, active-low
//    pc_current     in  32   PC register read data
//    branch_taken   in   1   branch resolved taken this cycle
//    branch_target  in  32   branch destination
//    hazard_stall   in   1   load-use stall request
//    int_req        in   1   interrupt request (level, held until int_ack)
//    ret_req        in   1   RET/RTI in memory stage (single-cycle pulse)
//    stk_ready      in   1   stack port finished current access
//    stk_rdata      in  16   popped stack word
//    pc_next        out 32   PC register write data
//    no_change      out  2   00 update, 01 hazard hold, 10 sequencer hold
//    stk_we         out  1   push request
//    stk_re         out  1   pop request
//    stk_wdata      out 16   pushed word (zero when not pushing)
//    int_ack        out  1   one-cycle pulse on interrupt acceptance
//    busy           out  1   high in every state except IDLE
// ============================================================================
module pc_sequencer #(
    parameter logic [31:0] PC_STEP    = 32'd1,
    parameter logic [31:0] INT_VECTOR = 32'h0000_0020
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] pc_current,
    input  logic        branch_taken,
    input  logic [31:0] branch_target,
    input  logic        hazard_stall,
    input  logic        int_req,
    input  logic        ret_req,
    input  logic        stk_ready,
    input  logic [15:0] stk_rdata,
    output logic [31:0] pc_next,
    output logic [1:0]  no_change,
    output logic        stk_we,
    output logic        stk_re,
    output logic [15:0] stk_wdata,
    output logic        int_ack,
    output logic        busy
);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        PUSH_HI = 3'd1,
        PUSH_LO = 3'd2,
        VEC     = 3'd3,
        POP_LO  = 3'd4,
        POP_HI  = 3'd5,
        LOAD    = 3'd6
    } state_t;

    state_t      state;
    state_t      state_d;
    logic [31:0] ret_addr;
    logic [31:0] ret_addr_d;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= IDLE;
            ret_addr <= '0;
        end else begin
            state    <= state_d;
            ret_addr <= ret_addr_d;
        end
    end

    always_comb begin
        state_d    = state;
        ret_addr_d = ret_addr;
        pc_next    = pc_current;
        no_change  = 2'b10;
        stk_we     = 1'b0;
        stk_re     = 1'b0;
        stk_wdata  = 16'h0000;
        int_ack    = 1'b0;
        busy       = (state != IDLE);

        case (state)
            IDLE: begin
                if (ret_req) begin
                    state_d = POP_LO;
                end else if (int_req) begin
                    int_ack = 1'b1;
                    // A branch resolving in the same cycle must be the
                    // resume point, otherwise the branch would be lost.
                    ret_addr_d = branch_taken ? branch_target : pc_current;
                    state_d    = PUSH_HI;
                end else if (branch_taken) begin
                    // Branch flush takes precedence over a load-use stall.
                    pc_next   = branch_target;
                    no_change = 2'b00;
                end else if (hazard_stall) begin
                    no_change = 2'b01;
                end else begin
                    pc_next   = pc_current + PC_STEP;
                    no_change = 2'b00;
                end
            end
            PUSH_HI: begin
                stk_we    = 1'b1;
                stk_wdata = ret_addr[31:16];
                if (stk_ready) state_d = PUSH_LO;
            end
            PUSH_LO: begin
                stk_we    = 1'b1;
                stk_wdata = ret_addr[15:0];
                if (stk_ready) state_d = VEC;
            end
            VEC: begin
                pc_next   = INT_VECTOR;
                no_change = 2'b00;
                state_d   = IDLE;
            end
            // Low word comes off first: it was the last one pushed.
            POP_LO: begin
                stk_re = 1'b1;
                if (stk_ready) begin
                    ret_addr_d[15:0] = stk_rdata;
                    state_d          = POP_HI;
                end
            end
            POP_HI: begin
                stk_re = 1'b1;
                if (stk_ready) begin
                    ret_addr_d[31:16] = stk_rdata;
                    state_d           = LOAD;
                end
            end
            LOAD: begin
                pc_next   = ret_addr;
                no_change = 2'b00;
                state_d   = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // While reset is asserted the PC register must see a hold and the
        // stack must see no strobes, regardless of the inputs.
        if (!rst) begin
            pc_next   = 32'h0000_0000;
            no_change = 2'b10;
            stk_we    = 1'b0;
            stk_re    = 1'b0;
            stk_wdata = 16'h0000;
            int_ack   = 1'b0;
            busy      = 1'b0;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_pc_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_pc_sequencer
//  Description : Self-checking bench for pc_sequencer. Directed scenarios
//                followed by randomized traffic, all compared against a
//                transaction-level reference model of the sequencer.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_pc_sequencer;

    localparam logic [31:0] PC_STEP    = 32'd1;
    localparam logic [31:0] INT_VECTOR = 32'h0000_0020;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [31:0] pc_current = '0;
    logic        branch_taken = 1'b0;
    logic [31:0] branch_target = '0;
    logic        hazard_stall = 1'b0;
    logic        int_req = 1'b0;
    logic        ret_req = 1'b0;
    logic        stk_ready = 1'b0;
    logic [15:0] stk_rdata = '0;
    logic [31:0] pc_next;
    logic [1:0]  no_change;
    logic        stk_we;
    logic        stk_re;
    logic [15:0] stk_wdata;
    logic        int_ack;
    logic        busy;

    pc_sequencer #(
        .PC_STEP    (PC_STEP),
        .INT_VECTOR (INT_VECTOR)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .pc_current    (pc_current),
        .branch_taken  (branch_taken),
        .branch_target (branch_target),
        .hazard_stall  (hazard_stall),
        .int_req       (int_req),
        .ret_req       (ret_req),
        .stk_ready     (stk_ready),
        .stk_rdata     (stk_rdata),
        .pc_next       (pc_next),
        .no_change     (no_change),
        .stk_we        (stk_we),
        .stk_re        (stk_re),
        .stk_wdata     (stk_wdata),
        .int_ack       (int_ack),
        .busy          (busy)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference model: which operation is in progress and how many of its
    // two stack words have been transferred so far.
    localparam int OP_NONE = 0;
    localparam int OP_INT  = 1;
    localparam int OP_RET  = 2;
    int          m_op    = OP_NONE;
    int          m_words = 0;
    logic [31:0] m_saved = '0;
    bit          e_ack;

    // One clock cycle: apply inputs after the posedge, check the Mealy
    // outputs before the negedge, then advance the model.
    task automatic cycle(input bit r, input bit br, input logic [31:0] tgt,
                         input bit hz, input bit ir, input bit rr, input bit rdy,
                         input logic [15:0] rd, input logic [31:0] pc);
        logic [31:0] e_pc;
        logic [1:0]  e_nc;
        bit          e_we, e_re, e_busy, chk_pc;
        logic [15:0] e_wd;
        @(posedge clk);
        #1;
        rst = r; branch_taken = br; branch_target = tgt; hazard_stall = hz;
        int_req = ir; ret_req = rr; stk_ready = rdy; stk_rdata = rd; pc_current = pc;
        #3;
        e_pc = pc; e_nc = 2'b10; e_we = 0; e_re = 0; e_wd = '0; e_ack = 0;
        e_busy = (m_op != OP_NONE); chk_pc = 1;
        if (!r) begin
            e_pc = '0; e_busy = 0;
            m_op = OP_NONE; m_words = 0; m_saved = '0;
        end else if (m_op == OP_NONE) begin
            if (rr) begin
                chk_pc = 0; m_op = OP_RET; m_words = 0;
            end else if (ir) begin
                chk_pc = 0; e_ack = 1; m_saved = br ? tgt : pc;
                m_op = OP_INT; m_words = 0;
            end else if (br) begin
                e_pc = tgt; e_nc = 2'b00;
            end else if (hz) begin
                e_nc = 2'b01;
            end else begin
                e_pc = pc + PC_STEP; e_nc = 2'b00;
            end
        end else if (m_words == 2) begin
            e_pc = (m_op == OP_INT) ? INT_VECTOR : m_saved;
            e_nc = 2'b00;
            m_op = OP_NONE;
        end else if (m_op == OP_INT) begin
            e_we = 1;
            e_wd = (m_words == 0) ? m_saved[31:16] : m_saved[15:0];
            if (rdy) m_words++;
        end else begin
            e_re = 1;
            if (rdy) begin
                if (m_words == 0) m_saved[15:0] = rd;
                else              m_saved[31:16] = rd;
                m_words++;
            end
        end
        if (chk_pc) check("pc_next", pc_next, e_pc);
        check("no_change", {30'd0, no_change}, {30'd0, e_nc});
        check("stk_we",    {31'd0, stk_we},    {31'd0, e_we});
        check("stk_re",    {31'd0, stk_re},    {31'd0, e_re});
        check("stk_wdata", {16'd0, stk_wdata}, {16'd0, e_wd});
        check("int_ack",   {31'd0, int_ack},   {31'd0, e_ack});
        check("busy",      {31'd0, busy},      {31'd0, e_busy});
    endtask

    task automatic idle_cycle(input logic [31:0] pc);
        cycle(1, 0, 32'h0, 0, 0, 0, 0, 16'h0, pc);
    endtask

    initial begin
        int  re_cycles;
        bit  ipend;
        bit  r, rr, rdy;

        // Reset state
        cycle(0, 0, 32'h0, 0, 1, 0, 1, 16'h0, 32'h1234);
        check("rst_pc", pc_next, 32'h0);
        check("rst_nc", {30'd0, no_change}, 32'd2);
        cycle(0, 1, 32'h99, 0, 0, 1, 1, 16'h0, 32'h1234);

        // Sequential fetch and wrap
        for (int i = 0; i < 3; i++) begin
            idle_cycle(32'h10);
            check("seq_pc", pc_next, 32'h11);
            check("seq_nc", {30'd0, no_change}, 32'd0);
        end
        idle_cycle(32'hFFFF_FFFF);
        check("wrap_pc", pc_next, 32'h0);

        // Branch beats stall; stall alone holds
        cycle(1, 1, 32'h80, 1, 0, 0, 0, 16'h0, 32'h10);
        check("br_pc", pc_next, 32'h80);
        check("br_nc", {30'd0, no_change}, 32'd0);
        cycle(1, 0, 32'h0, 1, 0, 0, 0, 16'h0, 32'h40);
        check("stall_pc", pc_next, 32'h40);
        check("stall_nc", {30'd0, no_change}, 32'd1);

        // Interrupt entry, zero wait
        cycle(1, 0, 32'h0, 0, 1, 0, 1, 16'h0, 32'h0001_2345);
        check("ack", {31'd0, int_ack}, 32'd1);
        cycle(1, 0, 32'h0, 0, 0, 0, 1, 16'h0, 32'h0001_2345);
        check("push_hi", {16'd0, stk_wdata}, 32'h0001);
        cycle(1, 0, 32'h0, 0, 0, 0, 1, 16'h0, 32'h0001_2345);
        check("push_lo", {16'd0, stk_wdata}, 32'h2345);
        cycle(1, 0, 32'h0, 0, 0, 0, 1, 16'h0, 32'h0001_2345);
        check("vec_pc", pc_next, 32'h20);
        idle_cycle(32'h20);
        check("int_done", {31'd0, busy}, 32'd0);

        // Return with two wait cycles per pop
        re_cycles = 0;
        cycle(1, 0, 32'h0, 0, 0, 1, 0, 16'h0, 32'h30);
        for (int i = 0; i < 6; i++) begin
            cycle(1, 0, 32'h0, 0, 0, 0, (i % 3) == 2,
                  (i < 3) ? 16'h2345 : 16'h0001, 32'h30);
            if (stk_re) re_cycles++;
        end
        check("re_cycles", re_cycles, 32'd6);
        cycle(1, 0, 32'h0, 0, 0, 0, 0, 16'h0, 32'h30);
        check("load_pc", pc_next, 32'h0001_2345);

        // Interrupt coinciding with a branch; RET during push is dropped
        cycle(1, 1, 32'hABCD, 0, 1, 0, 1, 16'h0, 32'h5555);
        cycle(1, 0, 32'h0, 0, 0, 0, 1, 16'h0, 32'h5555);
        check("brint_hi", {16'd0, stk_wdata}, 32'h0000);
        cycle(1, 0, 32'h0, 0, 0, 1, 1, 16'h0, 32'h5555);
        check("brint_lo", {16'd0, stk_wdata}, 32'hABCD);
        cycle(1, 0, 32'h0, 0, 0, 0, 1, 16'h0, 32'h5555);
        idle_cycle(32'h20);
        check("ret_lost", {31'd0, busy}, 32'd0);

        // Reset in POP_HI aborts at once
        cycle(1, 0, 32'h0, 0, 0, 1, 1, 16'h0, 32'h60);
        cycle(1, 0, 32'h0, 0, 0, 0, 1, 16'h1111, 32'h60);
        cycle(1, 0, 32'h0, 0, 0, 0, 0, 16'h2222, 32'h60);
        check("pop_hi_re", {31'd0, stk_re}, 32'd1);
        rst = 1'b0;
        #1;
        check("abort_re",   {31'd0, stk_re}, 32'd0);
        check("abort_busy", {31'd0, busy}, 32'd0);
        check("abort_pc",   pc_next, 32'h0);
        check("abort_nc",   {30'd0, no_change}, 32'd2);
        m_op = OP_NONE; m_words = 0; m_saved = '0;
        cycle(0, 0, 32'h0, 0, 0, 0, 0, 16'h0, 32'h60);
        idle_cycle(32'h60);
        check("post_rst", pc_next, 32'h61);

        // Randomized traffic
        ipend = 0;
        for (int i = 0; i < 3000; i++) begin
            if (!ipend && ($urandom % 20) == 0) ipend = 1;
            r   = ($urandom % 250) != 0;
            rr  = ($urandom % 15) == 0;
            rdy = ($urandom % 3) != 0;
            cycle(r, ($urandom % 4) == 0, $urandom, ($urandom % 4) == 0, ipend, rr, rdy,
                  16'($urandom), (($urandom % 8) == 0) ? 32'hFFFF_FFFF : $urandom);
            if (e_ack) ipend = 0;
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
